// File: rtl/up_down_count_pkg.sv
// Shared types for the up/down count decoder: tracker states, step classes,
// and the modular step classifier used on every accepted sample.
package up_down_count_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SYNC,
        ST_TRACK_UP,
        ST_TRACK_DN,
        ST_FAULT
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_INC,
        CLS_DEC,
        CLS_BAD
    } step_class_e;

    // Widest count bus the classifier can handle; callers zero-extend.
    localparam int unsigned MAX_WIDTH = 32;

    // Classify (cur - prev) mod 2^width. Only the low 'width' bits matter.
    function automatic step_class_e classify(
        input logic [MAX_WIDTH-1:0] cur,
        input logic [MAX_WIDTH-1:0] prev,
        input int                   width
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] delta;
        mask  = (width >= int'(MAX_WIDTH)) ? '1
              : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
        delta = (cur - prev) & mask;
        if (delta == '0) begin
            return CLS_ZERO;
        end else if (delta == MAX_WIDTH'(1)) begin
            return CLS_INC;
        end else if (delta == mask) begin
            return CLS_DEC;
        end else begin
            return CLS_BAD;
        end
    endfunction

endpackage

// File: rtl/up_down_count_decoder_filter.sv
// count_sample_filter: decides which SAMPLE_EN samples reach the tracker.
// Macro UP_DOWN_DECODE_FILTER_EN: when defined, a sample is accepted only if
// it equals the value captured at the previous SAMPLE_EN, which hides ripple
// transient codes. When undefined, every SAMPLE_EN is accepted directly.
module count_sample_filter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] count_in,
    output logic             accept,
    output logic [WIDTH-1:0] accept_val
);

    assign accept_val = count_in;

`ifdef UP_DOWN_DECODE_FILTER_EN
    logic [WIDTH-1:0] last_q, last_d;
    logic             have_q, have_d;

    // Capture every presented sample; CLEAR forgets history like RESET does.
    always_comb begin
        last_d = last_q;
        have_d = have_q;
        if (clear) begin
            last_d = '0;
            have_d = 1'b0;
        end else if (sample_en) begin
            last_d = count_in;
            have_d = 1'b1;
        end
    end

    // Register the previous-sample history.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= '0;
            have_q <= 1'b0;
        end else begin
            last_q <= last_d;
            have_q <= have_d;
        end
    end

    assign accept = sample_en & have_q & (count_in == last_q);
`else
    logic unused_filter_inputs;
    assign unused_filter_inputs = ^{clk, rst, clear};
    assign accept = sample_en;
`endif

endmodule

// File: rtl/up_down_count_decoder.sv
// up_down_count_decoder: watches a sampled up/down counter bus, recovers its
// direction, pulses on legal steps, wraps and reversals, and latches FAULT
// after ERR_LIMIT consecutive illegal jumps.
// Optional macro UP_DOWN_DECODE_FILTER_EN enables the repeat-sample filter.
//
// Handshake: SAMPLE_EN is a valid-only qualifier (no ready, no backpressure);
// COUNT_IN is consumed on every rising edge where SAMPLE_EN is high and
// neither RESET nor CLEAR is high.
module up_down_count_decoder
    import up_down_count_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLEAR,
    input  logic             SAMPLE_EN,
    input  logic [WIDTH-1:0] COUNT_IN,
    output logic             UPDN_OUT,
    output logic             DIR_VALID,
    output logic             STEP,
    output logic             WRAP,
    output logic             DIR_CHG,
    output logic             ERR,
    output state_e           dbg_state
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [2:0]       ERR_MAX = 3'(ERR_LIMIT);

    logic             accept;
    logic [WIDTH-1:0] accept_val;

    count_sample_filter #(.WIDTH(WIDTH)) u_filter (
        .clk        (CLK),
        .rst        (RESET),
        .clear      (CLEAR),
        .sample_en  (SAMPLE_EN),
        .count_in   (COUNT_IN),
        .accept     (accept),
        .accept_val (accept_val)
    );

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [2:0]       err_cnt_q, err_cnt_d;
    logic             updn_q, updn_d;
    logic             dir_valid_q, dir_valid_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             dir_chg_q, dir_chg_d;
    logic             err_q, err_d;
    step_class_e      cls;

    assign cls = classify(MAX_WIDTH'(accept_val), MAX_WIDTH'(prev_q), WIDTH);

    // Next-state, history and pulse computation for one accepted sample.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        err_cnt_d = err_cnt_q;
        updn_d    = updn_q;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
        dir_chg_d = 1'b0;
        if (CLEAR) begin
            // Soft restart: direction output keeps its last value.
            state_d   = ST_INIT;
            prev_d    = '0;
            err_cnt_d = '0;
        end else if (accept && state_q != ST_FAULT) begin
            prev_d = accept_val;
            unique case (state_q)
                ST_INIT: state_d = ST_SYNC;
                ST_SYNC: begin
                    if (cls == CLS_INC) begin
                        state_d = ST_TRACK_UP;
                        updn_d  = 1'b1;
                        step_d  = 1'b1;
                        wrap_d  = (prev_q == MAX_VAL);
                    end else if (cls == CLS_DEC) begin
                        state_d = ST_TRACK_DN;
                        updn_d  = 1'b0;
                        step_d  = 1'b1;
                        wrap_d  = (prev_q == '0);
                    end else if (cls == CLS_BAD) begin
                        err_cnt_d = err_cnt_q + 3'd1;
                    end
                end
                ST_TRACK_UP, ST_TRACK_DN: begin
                    if (cls == CLS_INC || cls == CLS_DEC) begin
                        step_d    = 1'b1;
                        err_cnt_d = '0;
                        updn_d    = (cls == CLS_INC);
                        wrap_d    = (cls == CLS_INC) ? (prev_q == MAX_VAL) : (prev_q == '0);
                        state_d   = (cls == CLS_INC) ? ST_TRACK_UP : ST_TRACK_DN;
                        dir_chg_d = (state_d != state_q);
                    end else if (cls == CLS_BAD) begin
                        err_cnt_d = err_cnt_q + 3'd1;
                    end
                end
                default: state_d = state_q;
            endcase
            if (err_cnt_d >= ERR_MAX) begin
                err_cnt_d = ERR_MAX;
                state_d   = ST_FAULT;
            end
        end
        dir_valid_d = (state_d == ST_TRACK_UP) || (state_d == ST_TRACK_DN);
        err_d       = (state_d == ST_FAULT);
    end

    // Single register stage for tracker state and every output.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_INIT;
            prev_q      <= '0;
            err_cnt_q   <= '0;
            updn_q      <= 1'b1;
            dir_valid_q <= 1'b0;
            step_q      <= 1'b0;
            wrap_q      <= 1'b0;
            dir_chg_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            err_cnt_q   <= err_cnt_d;
            updn_q      <= updn_d;
            dir_valid_q <= dir_valid_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
            dir_chg_q   <= dir_chg_d;
            err_q       <= err_d;
        end
    end

    assign UPDN_OUT  = updn_q;
    assign DIR_VALID = dir_valid_q;
    assign STEP      = step_q;
    assign WRAP      = wrap_q;
    assign DIR_CHG   = dir_chg_q;
    assign ERR       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_up_down_count_decoder.sv
// Bench for up_down_count_decoder: directed scenarios with literal pins plus
// randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_up_down_count_decoder;
    import up_down_count_pkg::*;

    localparam int WIDTH     = 4;
    localparam int ERR_LIMIT = 3;
    localparam int MOD       = 1 << WIDTH;

    // Clock and DUT signals
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic             clear = 1'b0;
    logic             sample_en = 1'b0;
    logic [WIDTH-1:0] count_in = '0;
    logic             updn_out, dir_valid, step, wrap, dir_chg, err;
    state_e           dbg_state;

    up_down_count_decoder #(.WIDTH(WIDTH), .ERR_LIMIT(ERR_LIMIT)) dut (
        .CLK       (clk),
        .RESET     (reset),
        .CLEAR     (clear),
        .SAMPLE_EN (sample_en),
        .COUNT_IN  (count_in),
        .UPDN_OUT  (updn_out),
        .DIR_VALID (dir_valid),
        .STEP      (step),
        .WRAP      (wrap),
        .DIR_CHG   (dir_chg),
        .ERR       (err),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Expected output word {UPDN, DIR_VALID, STEP, WRAP, DIR_CHG, ERR}
    logic [5:0] exp_q[$];

    function automatic logic [5:0] got_word();
        return {updn_out, dir_valid, step, wrap, dir_chg, err};
    endfunction

    // Behavioural model: direction as -1/0/+1, plain modular arithmetic.
    bit m_synced;
    int m_prev;
    int m_dir;
    bit m_fault;
    int m_err;
    bit m_updn;
    bit m_has_last;
    int m_last;

    function automatic logic [5:0] model_step(bit rst, bit clr, bit en, int val);
        bit st;
        bit wr;
        bit dc;
        bit acc;
        bit up;
        int d;
        st = 0; wr = 0; dc = 0;
        if (rst || clr) begin
            m_synced = 0; m_prev = 0; m_dir = 0; m_fault = 0; m_err = 0;
            m_has_last = 0; m_last = 0;
            if (rst) m_updn = 1;
        end else if (en) begin
            acc = 1;
`ifdef UP_DOWN_DECODE_FILTER_EN
            acc = m_has_last && (val == m_last);
            m_has_last = 1;
            m_last = val;
`endif
            if (acc && !m_fault) begin
                d = (((val - m_prev) % MOD) + MOD) % MOD;
                if (!m_synced) begin
                    m_synced = 1;
                end else if (d == 1 || d == MOD - 1) begin
                    up = (d == 1);
                    st = 1;
                    wr = up ? (m_prev == MOD - 1) : (m_prev == 0);
                    if (m_dir == 0) begin
                        m_dir = up ? 1 : -1;
                    end else if ((m_dir == 1) == up) begin
                        m_err = 0;
                    end else begin
                        dc = 1;
                        m_dir = up ? 1 : -1;
                        m_err = 0;
                    end
                    m_updn = up;
                end else if (d != 0) begin
                    m_err++;
                end
                m_prev = val;
                if (m_err >= ERR_LIMIT) begin
                    m_err = ERR_LIMIT;
                    m_fault = 1;
                    m_dir = 0;
                end
            end
        end
        return {m_updn, (m_dir != 0) && !m_fault, st, wr, dc, m_fault};
    endfunction

    // Driver: apply inputs away from the active edge, queue the expectation.
    task automatic drive(bit rst, bit clr, bit en, int val);
        @(negedge clk);
        reset     = rst;
        clear     = clr;
        sample_en = en;
        count_in  = val[WIDTH-1:0];
        exp_q.push_back(model_step(rst, clr, en, val));
    endtask

    // One logical count value; with the filter it must be seen twice.
    task automatic present(int val);
        drive(0, 0, 1, val);
`ifdef UP_DOWN_DECODE_FILTER_EN
        drive(0, 0, 1, val);
`endif
    endtask

    // Scoreboard: every cycle with a queued expectation is compared.
    always @(posedge clk) begin
        logic [5:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_word() !== e) begin
                errors++;
                $display("FAIL model_cmp t=%0t got=%b exp=%b (updn,dv,step,wrap,dchg,err)",
                         $time, got_word(), e);
            end
        end
    end

    // Hand-computed pin on the response to the most recent drive.
    task automatic pin(string name, logic [5:0] want);
        @(posedge clk);
        #2;
        checks++;
        if (got_word() !== want) begin
            errors++;
            $display("FAIL %s got=%b exp=%b (updn,dv,step,wrap,dchg,err)", name, got_word(), want);
        end
    endtask

    int cur;

    initial begin
        // Reset block
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        pin("reset", 6'b100000);
        checks++;
        if (dbg_state !== ST_INIT) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_INIT);
        end

        // Up count through a full wrap
        present(0);
        present(1);
        pin("first_step", 6'b111000);
        for (int v = 2; v < 16; v++) present(v);
        present(0);
        pin("wrap_up", 6'b111100);

        // Reverse at 7, count down through 0 to 15
        for (int v = 1; v < 8; v++) present(v);
        present(6);
        pin("dir_chg", 6'b011010);
        for (int v = 5; v >= 0; v--) present(v);
        present(15);
        pin("wrap_dn", 6'b011100);

        // CLEAR keeps UPDN_OUT low
        drive(0, 1, 0, 0);
        pin("clear_hold_dir", 6'b000000);

        // Three consecutive bad jumps force FAULT
        present(1);
        present(2);
        present(3);
        present(9);
        present(2);
        present(12);
        pin("fault", 6'b100001);
        present(13);
        pin("fault_ignores", 6'b100001);
        drive(0, 1, 0, 0);
        pin("clear_fault", 6'b100000);

        // Bad jumps followed by a good step reset the error count
        present(0);
        present(1);
        present(3);
        pin("bad_no_step", 6'b110000);
        present(5);
        present(6);
        pin("recover_step", 6'b111000);
        present(9);
        present(12);
        pin("no_fault_after_reset", 6'b110000);

        // Sample during CLEAR is discarded
        drive(0, 1, 1, 4);
        present(5);
        pin("clear_drop_sync", 6'b100000);
        present(6);
        pin("after_clear_step", 6'b111000);

`ifdef UP_DOWN_DECODE_FILTER_EN
        // Ripple glitch is filtered out; only the repeated 8 is accepted
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 7);
        drive(0, 0, 1, 6);
        pin("glitch_ignored", 6'b100000);
        drive(0, 0, 1, 8);
        drive(0, 0, 1, 8);
        pin("filter_init", 6'b100000);
        drive(0, 0, 1, 9);
        drive(0, 0, 1, 9);
        pin("filter_step", 6'b111000);
`endif

        // Randomized traffic
        cur = 0;
        for (int i = 0; i < 600; i++) begin
            int r;
            int k;
            r = $urandom_range(0, 99);
            k = $urandom_range(0, 9);
            if (k < 3) cur = (cur + 1) % MOD;
            else if (k < 5) cur = (cur + MOD - 1) % MOD;
            else if (k == 9) cur = $urandom_range(0, MOD - 1);
            drive(r < 1, (r >= 1) && (r < 4), $urandom_range(0, 3) != 0, cur);
        end

        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
